// File: rtl/hash_absorb_ctrl_if.sv
// Control, public-key memory, Keccak lane and permutation signals of the absorb controller.
interface hash_absorb_ctrl_if;
  localparam int unsigned MSG_W  = 128;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned LANE_W = 64;

  logic              start;
  logic              abort;
  logic [MSG_W-1:0]  genmat_message;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [WORD_W-1:0] mem_rd_PK;
  logic              lane_valid;
  logic [LANE_W-1:0] lane_data;
  logic              lane_ready;
  logic              perm_start;
  logic              perm_done;
  logic              busy;
  logic              done;

  // Controller side.
  modport master (
    input  start, abort, genmat_message, mem_rd_PK, lane_ready, perm_done,
    output mem_rd_en, mem_rd_addr, lane_valid, lane_data, perm_start, busy, done
  );

  // Environment side: job requester, key memory and Keccak core.
  modport slave (
    output start, abort, genmat_message, mem_rd_PK, lane_ready, perm_done,
    input  mem_rd_en, mem_rd_addr, lane_valid, lane_data, perm_start, busy, done
  );
endinterface

// File: rtl/hash_absorb_ctrl.sv
// Absorbs the public key (packed four 16-bit words per lane), then the two message
// lanes, then sponge padding, into a Keccak core one lane at a time.
module hash_absorb_ctrl #(
  parameter int unsigned PK_WORDS   = 580,
  parameter int unsigned PK_BASE    = 0,
  parameter int unsigned RATE_LANES = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  hash_absorb_ctrl_if.master bus
);

  localparam int unsigned MSG_W       = 128;
  localparam int unsigned ADDR_W      = 11;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned LANE_W      = 64;
  localparam int unsigned PK_LANES    = PK_WORDS / 4;
  localparam int unsigned DATA_LANES  = PK_LANES + 2;
  localparam int unsigned DATA_REM    = DATA_LANES % RATE_LANES;
  localparam int unsigned PAD_LANES   = (DATA_REM == 0) ? RATE_LANES : (RATE_LANES - DATA_REM);
  localparam int unsigned TOTAL_LANES = DATA_LANES + PAD_LANES;
  localparam int unsigned IDX_W       = $clog2(TOTAL_LANES + 1);
  localparam int unsigned BLK_W       = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_PUSH, S_PERM, S_PAD, S_DONE
  } state_t;

  state_t            state, state_n;

  logic              rd_en_q, rd_en_n;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_n;
  logic              lane_valid_q, lane_valid_n;
  logic [LANE_W-1:0] lane_data_q, lane_data_n;
  logic              perm_start_q, perm_start_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic [MSG_W-1:0]  msg_q, msg_n;
  logic [IDX_W-1:0]  lane_idx_q, lane_idx_n;
  logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_n;
  logic [2:0]        rd_cnt_q, rd_cnt_n;
  logic [1:0]        cap_idx_q, cap_idx_n;
  logic              rd_pend_q, rd_pend_n;

  logic              accept;
  logic              blk_last;
  logic              fetch_done;
  logic [IDX_W-1:0]  disp_idx;
  logic [BLK_W-1:0]  disp_blk;
  state_t            disp_state;
  logic [LANE_W-1:0] pad_lane;

  // Shared decode: lane handshake, block end, fetch completion and where the next lane comes from.
  always_comb begin
    accept     = 1'b0;
    blk_last   = 1'b0;
    fetch_done = 1'b0;
    disp_idx   = lane_idx_q;
    disp_blk   = blk_cnt_q;
    disp_state = S_DONE;
    pad_lane   = '0;

    accept     = ((state == S_PUSH) || (state == S_PAD)) && lane_valid_q && bus.lane_ready;
    blk_last   = (blk_cnt_q == BLK_W'(RATE_LANES - 1));
    fetch_done = (state == S_FETCH) && rd_pend_q && (cap_idx_q == 2'd3);

    // Leaving PERM the counters already point at the next lane; otherwise it is one past the current.
    if (state != S_PERM) begin
      disp_idx = lane_idx_q + IDX_W'(1);
      disp_blk = blk_cnt_q + BLK_W'(1);
    end

    if (disp_idx < IDX_W'(PK_LANES)) begin
      disp_state = S_FETCH;
    end else if (disp_idx < IDX_W'(DATA_LANES)) begin
      disp_state = S_PUSH;
    end else if (disp_idx < IDX_W'(TOTAL_LANES)) begin
      disp_state = S_PAD;
    end

    if (disp_idx == IDX_W'(DATA_LANES)) begin
      pad_lane[4:0] = 5'h1F;
    end
    if (disp_blk == BLK_W'(RATE_LANES - 1)) begin
      pad_lane[LANE_W-1] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; abort overrides any pending handshake or permutation completion.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (bus.start) state_n = (PK_LANES > 0) ? S_FETCH : S_PUSH;
      S_FETCH: if (fetch_done) state_n = S_PUSH;
      S_PUSH,
      S_PAD:   if (accept) state_n = blk_last ? S_PERM : disp_state;
      S_PERM:  if (bus.perm_done) state_n = disp_state;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (bus.abort && (state != S_IDLE)) begin
      state_n = S_IDLE;
    end
  end

  // Output and datapath next values, registered below.
  always_comb begin
    rd_en_n      = 1'b0;
    rd_addr_n    = rd_addr_q;
    lane_valid_n = lane_valid_q;
    lane_data_n  = lane_data_q;
    perm_start_n = 1'b0;
    busy_n       = (state_n != S_IDLE) && (state_n != S_DONE);
    done_n       = (state_n == S_DONE);
    msg_n        = msg_q;
    lane_idx_n   = lane_idx_q;
    blk_cnt_n    = blk_cnt_q;
    rd_cnt_n     = rd_cnt_q;
    cap_idx_n    = cap_idx_q;
    rd_pend_n    = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          msg_n        = bus.genmat_message;
          rd_addr_n    = ADDR_W'(PK_BASE);
          lane_idx_n   = '0;
          blk_cnt_n    = '0;
          cap_idx_n    = '0;
          lane_data_n  = '0;
          lane_valid_n = 1'b0;
          if (PK_LANES > 0) begin
            rd_en_n  = 1'b1;
            rd_cnt_n = 3'd1;
          end else begin
            lane_valid_n = 1'b1;
            lane_data_n  = bus.genmat_message[MSG_W-1:LANE_W];
          end
        end
      end
      S_FETCH: begin
        // Four back-to-back strobes; each word is captured the cycle after its strobe.
        rd_pend_n = rd_en_q;
        if (rd_en_q && (rd_cnt_q != 3'd4)) begin
          rd_en_n   = 1'b1;
          rd_addr_n = rd_addr_q + ADDR_W'(1);
          rd_cnt_n  = rd_cnt_q + 3'd1;
        end
        if (rd_pend_q) begin
          lane_data_n[{cap_idx_q, 4'd0} +: WORD_W] = bus.mem_rd_PK;
          cap_idx_n = cap_idx_q + 2'd1;
        end
        if (fetch_done) begin
          lane_valid_n = 1'b1;
        end
      end
      S_PUSH,
      S_PAD: begin
        if (accept) begin
          lane_valid_n = 1'b0;
          lane_idx_n   = lane_idx_q + IDX_W'(1);
          blk_cnt_n    = blk_last ? '0 : (blk_cnt_q + BLK_W'(1));
          perm_start_n = blk_last;
        end
      end
      default: ;
    endcase

    // Set up the next lane source on entry to FETCH, PUSH or PAD.
    if ((accept && !blk_last) || ((state == S_PERM) && bus.perm_done)) begin
      case (disp_state)
        S_FETCH: begin
          rd_en_n      = 1'b1;
          rd_addr_n    = rd_addr_q + ADDR_W'(1);
          rd_cnt_n     = 3'd1;
          cap_idx_n    = '0;
          lane_valid_n = 1'b0;
        end
        S_PUSH: begin
          lane_valid_n = 1'b1;
          lane_data_n  = (disp_idx == IDX_W'(PK_LANES)) ? msg_q[MSG_W-1:LANE_W] : msg_q[LANE_W-1:0];
        end
        S_PAD: begin
          lane_valid_n = 1'b1;
          lane_data_n  = pad_lane;
        end
        default: ;
      endcase
    end

    if (bus.abort && (state != S_IDLE)) begin
      rd_en_n      = 1'b0;
      rd_addr_n    = '0;
      lane_valid_n = 1'b0;
      lane_data_n  = '0;
      perm_start_n = 1'b0;
      busy_n       = 1'b0;
      done_n       = 1'b0;
      msg_n        = '0;
      lane_idx_n   = '0;
      blk_cnt_n    = '0;
      rd_cnt_n     = '0;
      cap_idx_n    = '0;
      rd_pend_n    = 1'b0;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      lane_valid_q <= 1'b0;
      lane_data_q  <= '0;
      perm_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      msg_q        <= '0;
      lane_idx_q   <= '0;
      blk_cnt_q    <= '0;
      rd_cnt_q     <= '0;
      cap_idx_q    <= '0;
      rd_pend_q    <= 1'b0;
    end else begin
      rd_en_q      <= rd_en_n;
      rd_addr_q    <= rd_addr_n;
      lane_valid_q <= lane_valid_n;
      lane_data_q  <= lane_data_n;
      perm_start_q <= perm_start_n;
      busy_q       <= busy_n;
      done_q       <= done_n;
      msg_q        <= msg_n;
      lane_idx_q   <= lane_idx_n;
      blk_cnt_q    <= blk_cnt_n;
      rd_cnt_q     <= rd_cnt_n;
      cap_idx_q    <= cap_idx_n;
      rd_pend_q    <= rd_pend_n;
    end
  end

  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.lane_valid  = lane_valid_q;
  assign bus.lane_data   = lane_data_q;
  assign bus.perm_start  = perm_start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
